// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, control-word layout, idle word.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int unsigned CW_WIDTH           = 16;
    localparam int unsigned CW_PC_ENABLE       = 0;
    localparam int unsigned CW_PC_BUS_ENABLE_N = 1;
    localparam int unsigned CW_JUMP_N          = 2;
    localparam int unsigned CW_MAR_LOAD_N      = 3;
    localparam int unsigned CW_RAM_LOAD_N      = 4;
    localparam int unsigned CW_RAM_OUT_N       = 5;
    localparam int unsigned CW_IR_LOAD_N       = 6;
    localparam int unsigned CW_IR_OUT_N        = 7;
    localparam int unsigned CW_A_LOAD_N        = 8;
    localparam int unsigned CW_A_OUT_N         = 9;
    localparam int unsigned CW_B_LOAD_N        = 10;
    localparam int unsigned CW_SUM_OUT_N       = 11;
    localparam int unsigned CW_OUT_LOAD_N      = 12;
    localparam int unsigned CW_FLAGS_LOAD_N    = 13;
    localparam int unsigned CW_SUBTRACT        = 14;
    localparam int unsigned CW_HALT            = 15;

    // Active-low strobes sit at 1, active-high controls at 0.
    localparam logic [CW_WIDTH-1:0] CW_IDLE = 16'h3FFE;

    // Drive one control-word bit to its active level.
    function automatic logic [CW_WIDTH-1:0] cw_assert(input logic [CW_WIDTH-1:0] cw,
                                                      input int unsigned idx);
        logic [CW_WIDTH-1:0] res;
        res = cw;
        res[idx] = ~CW_IDLE[idx];
        return res;
    endfunction

endpackage

// File: rtl/control_rom.sv
// Combinational microcode decode: (step, opcode, flags) -> control word.
// JC/JZ are decoded only when CONDITIONAL_JUMP_EN is defined; otherwise they act as NOP.
module control_rom
    import sap_pkg::*;
(
    input  logic [2:0]          step,
    input  logic [3:0]          opcode,
    input  logic                carry,
    input  logic                zero,
    output logic [CW_WIDTH-1:0] cw
);

`ifndef CONDITIONAL_JUMP_EN
    logic unused_flags;
    assign unused_flags = carry ^ zero;
`endif

    always_comb begin
        cw = CW_IDLE;
        case (step)
            3'd0: begin
                cw = cw_assert(cw, CW_PC_BUS_ENABLE_N);
                cw = cw_assert(cw, CW_MAR_LOAD_N);
            end
            3'd1: begin
                cw = cw_assert(cw, CW_RAM_OUT_N);
                cw = cw_assert(cw, CW_IR_LOAD_N);
                cw = cw_assert(cw, CW_PC_ENABLE);
            end
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw = cw_assert(cw, CW_IR_OUT_N);
                        cw = cw_assert(cw, CW_MAR_LOAD_N);
                    end
                    OP_LDI: begin
                        cw = cw_assert(cw, CW_IR_OUT_N);
                        cw = cw_assert(cw, CW_A_LOAD_N);
                    end
                    OP_JMP: begin
                        cw = cw_assert(cw, CW_IR_OUT_N);
                        cw = cw_assert(cw, CW_JUMP_N);
                    end
`ifdef CONDITIONAL_JUMP_EN
                    OP_JC, OP_JZ: begin
                        if ((opcode == OP_JC) ? carry : zero) begin
                            cw = cw_assert(cw, CW_IR_OUT_N);
                            cw = cw_assert(cw, CW_JUMP_N);
                        end
                    end
`endif
                    OP_OUT: begin
                        cw = cw_assert(cw, CW_A_OUT_N);
                        cw = cw_assert(cw, CW_OUT_LOAD_N);
                    end
                    OP_HLT: cw = cw_assert(cw, CW_HALT);
                    default: ;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA: begin
                        cw = cw_assert(cw, CW_RAM_OUT_N);
                        cw = cw_assert(cw, CW_A_LOAD_N);
                    end
                    OP_ADD, OP_SUB: begin
                        cw = cw_assert(cw, CW_RAM_OUT_N);
                        cw = cw_assert(cw, CW_B_LOAD_N);
                    end
                    OP_STA: begin
                        cw = cw_assert(cw, CW_A_OUT_N);
                        cw = cw_assert(cw, CW_RAM_LOAD_N);
                    end
                    default: ;
                endcase
            end
            3'd4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw = cw_assert(cw, CW_SUM_OUT_N);
                    cw = cw_assert(cw, CW_A_LOAD_N);
                    cw = cw_assert(cw, CW_FLAGS_LOAD_N);
                    if (opcode == OP_SUB) cw = cw_assert(cw, CW_SUBTRACT);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP control sequencer: micro-step counter, sticky halt and control-word fan-out.
// Conditional jumps are enabled by defining CONDITIONAL_JUMP_EN.
module control_sequencer
    import sap_pkg::*;
#(
    parameter int unsigned STEPS = 5
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_enable,
    output logic       pc_bus_enable_n,
    output logic       jump_n,
    output logic       mar_load_n,
    output logic       ram_load_n,
    output logic       ram_out_n,
    output logic       ir_load_n,
    output logic       ir_out_n,
    output logic       a_load_n,
    output logic       a_out_n,
    output logic       b_load_n,
    output logic       sum_out_n,
    output logic       out_load_n,
    output logic       flags_load_n,
    output logic       subtract,
    output logic       halt,
    output logic [2:0] step
);

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    logic [2:0]          step_q;
    logic                halted_q;
    logic [CW_WIDTH-1:0] rom_cw;
    logic [CW_WIDTH-1:0] cw;

    control_rom u_control_rom (
        .step   (step_q),
        .opcode (opcode),
        .carry  (carry_flag),
        .zero   (zero_flag),
        .cw     (rom_cw)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            step_q   <= 3'd0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (step_q == 3'd2 && opcode == OP_HLT) begin
                halted_q <= 1'b1;
            end else if (step_q == LAST_STEP) begin
                step_q <= 3'd0;
            end else begin
                step_q <= step_q + 3'd1;
            end
        end
    end

    // Clear gates the word directly so strobes drop without waiting for a clock.
    always_comb begin
        cw = rom_cw;
        if (clear) begin
            cw = CW_IDLE;
        end else if (halted_q) begin
            cw = cw_assert(CW_IDLE, CW_HALT);
        end
    end

    assign pc_enable       = cw[CW_PC_ENABLE];
    assign pc_bus_enable_n = cw[CW_PC_BUS_ENABLE_N];
    assign jump_n          = cw[CW_JUMP_N];
    assign mar_load_n      = cw[CW_MAR_LOAD_N];
    assign ram_load_n      = cw[CW_RAM_LOAD_N];
    assign ram_out_n       = cw[CW_RAM_OUT_N];
    assign ir_load_n       = cw[CW_IR_LOAD_N];
    assign ir_out_n        = cw[CW_IR_OUT_N];
    assign a_load_n        = cw[CW_A_LOAD_N];
    assign a_out_n         = cw[CW_A_OUT_N];
    assign b_load_n        = cw[CW_B_LOAD_N];
    assign sum_out_n       = cw[CW_SUM_OUT_N];
    assign out_load_n      = cw[CW_OUT_LOAD_N];
    assign flags_load_n    = cw[CW_FLAGS_LOAD_N];
    assign subtract        = cw[CW_SUBTRACT];
    assign halt            = cw[CW_HALT];
    assign step            = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a reference model pushes the expected step and
// control word each cycle; the observed outputs are popped and compared mid-cycle.
module tb_control_sequencer;

    localparam int unsigned STEPS = 5;

    // Bench-side bit positions of the packed observed word.
    localparam int PCE = 0, PCB = 1, JMPN = 2, MAR = 3, RAML = 4, RAMO = 5, IRL = 6,
                   IRO = 7, AL = 8, AO = 9, BL = 10, SUMO = 11, OUTL = 12, FLG = 13,
                   SUB = 14, HLT = 15;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic       pc_enable, pc_bus_enable_n, jump_n, mar_load_n, ram_load_n, ram_out_n;
    logic       ir_load_n, ir_out_n, a_load_n, a_out_n, b_load_n, sum_out_n, out_load_n;
    logic       flags_load_n, subtract, halt;
    logic [2:0] step;

    control_sequencer #(.STEPS(STEPS)) dut (
        .clk             (clk),
        .clear           (clear),
        .opcode          (opcode),
        .carry_flag      (carry_flag),
        .zero_flag       (zero_flag),
        .pc_enable       (pc_enable),
        .pc_bus_enable_n (pc_bus_enable_n),
        .jump_n          (jump_n),
        .mar_load_n      (mar_load_n),
        .ram_load_n      (ram_load_n),
        .ram_out_n       (ram_out_n),
        .ir_load_n       (ir_load_n),
        .ir_out_n        (ir_out_n),
        .a_load_n        (a_load_n),
        .a_out_n         (a_out_n),
        .b_load_n        (b_load_n),
        .sum_out_n       (sum_out_n),
        .out_load_n      (out_load_n),
        .flags_load_n    (flags_load_n),
        .subtract        (subtract),
        .halt            (halt),
        .step            (step)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {halt, subtract, flags_load_n, out_load_n, sum_out_n, b_load_n, a_out_n,
                  a_load_n, ir_out_n, ir_load_n, ram_out_n, ram_load_n, mar_load_n, jump_n,
                  pc_bus_enable_n, pc_enable};

    int n_checks = 0;
    int n_pass   = 0;

    logic [18:0] sb_q[$];
    int          m_step = 0;
    bit          m_halted = 1'b0;
    logic [3:0]  m_last_opc = 4'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Word with only the listed active signals asserted; active-high: PCE, SUB, HLT.
    function automatic logic [15:0] on(input logic [15:0] w, input int b);
        logic [15:0] r;
        r = w;
        r[b] = (b == PCE || b == SUB || b == HLT) ? 1'b1 : 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] exp_word(input int s, input logic [3:0] opc, input bit c,
                                             input bit z, input bit halted, input bit clr);
        logic [15:0] w;
        w = 16'h3FFE;
        if (clr) return w;
        if (halted) return on(w, HLT);
        if (s == 0) begin
            w = on(on(w, PCB), MAR);
        end else if (s == 1) begin
            w = on(on(on(w, RAMO), IRL), PCE);
        end else if (s == 2) begin
            case (opc)
                4'h1, 4'h2, 4'h3, 4'h4: w = on(on(w, IRO), MAR);
                4'h5: w = on(on(w, IRO), AL);
                4'h6: w = on(on(w, IRO), JMPN);
`ifdef CONDITIONAL_JUMP_EN
                4'h7: if (c) w = on(on(w, IRO), JMPN);
                4'h8: if (z) w = on(on(w, IRO), JMPN);
`endif
                4'hE: w = on(on(w, AO), OUTL);
                4'hF: w = on(w, HLT);
                default: ;
            endcase
        end else if (s == 3) begin
            if (opc == 4'h1) w = on(on(w, RAMO), AL);
            if (opc == 4'h2 || opc == 4'h3) w = on(on(w, RAMO), BL);
            if (opc == 4'h4) w = on(on(w, AO), RAML);
        end else if (s == 4 && (opc == 4'h2 || opc == 4'h3)) begin
            w = on(on(on(w, SUMO), AL), FLG);
            if (opc == 4'h3) w = on(w, SUB);
        end
        return w;
    endfunction

    task automatic compare(input string tag);
        logic [18:0] e;
        int drivers;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_step"}, {29'd0, step}, {29'd0, e[18:16]});
        check({tag, "_word"}, {16'd0, obs}, {16'd0, e[15:0]});
        drivers = int'(!pc_bus_enable_n) + int'(!ram_out_n) + int'(!ir_out_n) +
                  int'(!a_out_n) + int'(!sum_out_n);
        check({tag, "_bus"}, {31'd0, drivers <= 1}, 32'd1);
    endtask

    // One clock: advance the model, drive inputs, push expectation, compare mid-cycle.
    task automatic cycle(input string tag, input logic [3:0] opc, input bit c, input bit z);
        @(posedge clk);
        #1;
        if (!m_halted) begin
            if (m_step == 2 && m_last_opc == 4'hF) m_halted = 1'b1;
            else m_step = (m_step == int'(STEPS) - 1) ? 0 : m_step + 1;
        end
        opcode = opc;
        carry_flag = c;
        zero_flag = z;
        m_last_opc = opc;
        sb_q.push_back({3'(m_step), exp_word(m_step, opc, c, z, m_halted, 1'b0)});
        #1;
        compare(tag);
    endtask

    task automatic run(input string tag, input logic [3:0] opc, input bit c, input bit z,
                       input int n);
        for (int i = 0; i < n; i++) cycle(tag, opc, c, z);
    endtask

    // Asynchronous clear mid-cycle, held across one edge, released before the next.
    task automatic do_clear(input string tag);
        #2;
        clear = 1'b1;
        m_step = 0;
        m_halted = 1'b0;
        sb_q.push_back({3'd0, exp_word(0, opcode, 1'b0, 1'b0, 1'b0, 1'b1)});
        #1;
        compare({tag, "_clr"});
        @(posedge clk);
        #2;
        clear = 1'b0;
        sb_q.push_back({3'd0, exp_word(0, opcode, 1'b0, 1'b0, 1'b0, 1'b0)});
        #1;
        compare({tag, "_t0"});
    endtask

    initial begin
        #1;
        sb_q.push_back({3'd0, exp_word(0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1)});
        compare("reset");
        @(posedge clk);
        #2;
        clear = 1'b0;
        sb_q.push_back({3'd0, exp_word(0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0)});
        #1;
        compare("rel_t0");

        run("lda", 4'h1, 1'b0, 1'b0, STEPS);
        run("add", 4'h2, 1'b0, 1'b0, STEPS);
        run("sub", 4'h3, 1'b1, 1'b1, STEPS);
        run("jc0", 4'h7, 1'b0, 1'b1, STEPS);
        run("jc1", 4'h7, 1'b1, 1'b0, STEPS);
        run("jz0", 4'h8, 1'b1, 1'b0, STEPS);
        run("jz1", 4'h8, 1'b0, 1'b1, STEPS);
        run("sta", 4'h4, 1'b0, 1'b0, STEPS);
        run("ldi", 4'h5, 1'b0, 1'b0, STEPS);
        run("out", 4'hE, 1'b0, 1'b0, STEPS);
        run("jmp", 4'h6, 1'b0, 1'b0, STEPS);
        run("nop", 4'h0, 1'b0, 1'b0, STEPS);
        run("unk", 4'hA, 1'b1, 1'b1, STEPS);

        // LDA up to T3, then clear mid-cycle.
        run("lda_mid", 4'h1, 1'b0, 1'b0, 3);
        do_clear("abort");

        // HLT: reach T2 then stay frozen.
        run("hlt", 4'hF, 1'b0, 1'b0, 2);
        run("halted", 4'hF, 1'b0, 1'b0, 10);
        run("halted_op", 4'h2, 1'b1, 1'b1, 3);
        do_clear("unhalt");

        for (int i = 0; i < 30; i++) begin
            logic [3:0] r_opc;
            r_opc = 4'($urandom_range(0, 15));
            if (r_opc == 4'hF) r_opc = 4'h0;
            cycle("rand", r_opc, 1'($urandom), 1'($urandom));
        end

        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
